fft_frame_packer: RTL and testbench

- Sits between the FIR output and the FFT core input in the DDS→FIR→FFT chain.
- Takes a free-running FIR sample stream and converts it (arithmetic shift, then saturation) from IN_W to OUT_W bits.
- Buffers samples in an internal FIFO and emits exactly FRAME_LEN-sample frames with sop/eop framing and a valid/ready handshake to the FFT.
- Counts dropped samples on overflow; overflow is never silent.

---
 rtl/fft_frame_packer.sv | 150 +++++++++++++++
 tb/tb_fft_frame_packer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_packer.sv
// Converts a free-running FIR sample stream to OUT_W bits, buffers it in a FIFO
// and emits FRAME_LEN-sample frames with sop/eop framing to the FFT core.
module fft_frame_packer #(
   parameter int IN_W       = 37,
   parameter int OUT_W      = 32,
   parameter int SHIFT      = 5,
   parameter int FRAME_LEN  = 1024,
   parameter int FIFO_DEPTH = 2048,
   localparam int IDX_W     = $clog2(FRAME_LEN),
   localparam int AW        = $clog2(FIFO_DEPTH),
   localparam int LW        = AW + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [IN_W-1:0]  din,
   input  logic                    din_valid,
   input  logic                    fft_ready,
   output logic signed [OUT_W-1:0] fft_data,
   output logic                    fft_valid,
   output logic                    fft_sop,
   output logic                    fft_eop,
   output logic [IDX_W-1:0]        fft_idx,
   output logic [LW-1:0]           fifo_level,
   output logic                    overflow,
   output logic [15:0]             drop_cnt,
   output logic [15:0]             frame_cnt
);

   localparam logic signed [IN_W-1:0] SAT_MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W-1:0] SAT_MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   function automatic logic signed [OUT_W-1:0] sat_conv(input logic signed [IN_W-1:0] x);
      logic signed [IN_W-1:0] t;
      t = x >>> SHIFT;
      if (t > SAT_MAX)
         return SAT_MAX[OUT_W-1:0];
      else if (t < SAT_MIN)
         return SAT_MIN[OUT_W-1:0];
      else
         return t[OUT_W-1:0];
   endfunction

   typedef enum logic {IDLE, SEND} state_t;

   state_t                 state;
   logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr;
   logic [AW-1:0]          rd_ptr;
   logic                   wr_en;
   logic                   rd_en;
   logic                   xfer;
   logic                   frame_ready;
   logic signed [OUT_W-1:0] rd_word;

   assign xfer        = fft_valid & fft_ready;
   assign frame_ready = (fifo_level >= LW'(FRAME_LEN));
   assign rd_word     = mem[rd_ptr];

   // A pop happens exactly when the output register loads a new word.
   always_comb begin
      rd_en = 1'b0;
      case (state)
         IDLE: rd_en = frame_ready;
         SEND: rd_en = xfer & (~fft_eop | frame_ready);
         default: rd_en = 1'b0;
      endcase
      wr_en = din_valid & ((fifo_level < LW'(FIFO_DEPTH)) | rd_en);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= sat_conv(din);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
         drop_cnt   <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   fifo_level <= fifo_level + 1'b1;
            2'b01:   fifo_level <= fifo_level - 1'b1;
            default: fifo_level <= fifo_level;
         endcase
         if (din_valid && !wr_en) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF)
               drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   // Output register: holds while stalled, reloads on every transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         fft_valid <= 1'b0;
         fft_sop   <= 1'b0;
         fft_eop   <= 1'b0;
         fft_data  <= '0;
         fft_idx   <= '0;
         frame_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rd_en) begin
                  state     <= SEND;
                  fft_valid <= 1'b1;
                  fft_data  <= rd_word;
                  fft_idx   <= '0;
                  fft_sop   <= 1'b1;
                  fft_eop   <= 1'b0;
               end
            end
            SEND: begin
               if (xfer) begin
                  if (fft_eop) begin
                     frame_cnt <= frame_cnt + 1'b1;
                     if (rd_en) begin
                        fft_data <= rd_word;
                        fft_idx  <= '0;
                        fft_sop  <= 1'b1;
                        fft_eop  <= 1'b0;
                     end else begin
                        state     <= IDLE;
                        fft_valid <= 1'b0;
                        fft_sop   <= 1'b0;
                        fft_eop   <= 1'b0;
                     end
                  end else begin
                     fft_data <= rd_word;
                     fft_idx  <= fft_idx + 1'b1;
                     fft_sop  <= 1'b0;
                     fft_eop  <= (fft_idx == IDX_W'(FRAME_LEN - 2));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer: two instances (SHIFT=0 and SHIFT=5)
// share one stimulus stream; expected samples are queued as they are driven.
module tb_fft_frame_packer;

   localparam int IN_W = 37;
   localparam int OUT_W = 32;
   localparam int FL = 1024;
   localparam int FD = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic signed [IN_W-1:0]  din;
   logic                    din_valid;
   logic                    fft_ready;

   logic [31:0] d0, d1;
   logic        v0, v1, s0, s1, e0, e1, o0, o1;
   logic [9:0]  i0, i1;
   logic [11:0] l0, l1;
   logic [15:0] dc0, dc1, fc0, fc1;

   fft_frame_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(0), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut0 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fft_ready(fft_ready),
      .fft_data(d0), .fft_valid(v0), .fft_sop(s0), .fft_eop(e0), .fft_idx(i0),
      .fifo_level(l0), .overflow(o0), .drop_cnt(dc0), .frame_cnt(fc0));

   fft_frame_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(5), .FRAME_LEN(FL), .FIFO_DEPTH(FD)) dut5 (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .fft_ready(fft_ready),
      .fft_data(d1), .fft_valid(v1), .fft_sop(s1), .fft_eop(e1), .fft_idx(i1),
      .fifo_level(l1), .overflow(o1), .drop_cnt(dc1), .frame_cnt(fc1));

   int checks = 0;
   int errors = 0;

   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          beat[2];
   int          frames[2];
   int          sops[2];
   int          exp_nv[2];
   logic        stall[2];
   logic [31:0] hd[2];
   logic [9:0]  hi[2];
   logic        hs[2];
   logic        he[2];

   typedef struct {
      logic signed [IN_W-1:0] din;
      logic [31:0]            exp0;
      logic [31:0]            exp5;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string name, input int w, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, w, act, exp);
      end
   endtask

   function automatic logic [31:0] conv(input logic signed [IN_W-1:0] x, input int sh);
      longint t;
      t = longint'(x);
      t = t >>> sh;
      if (t > 64'sd2147483647) return 32'h7FFF_FFFF;
      if (t < -64'sd2147483648) return 32'h8000_0000;
      return t[31:0];
   endfunction

   task automatic mon(input int w, input logic v, input logic s, input logic e,
                      input logic [9:0] idx, input logic [31:0] d);
      logic [31:0] exp;
      int          qs;
      if (exp_nv[w] >= 0) begin
         chk("valid_after_eop", w, v, exp_nv[w] == 1);
         if (exp_nv[w] == 1) chk("sop_after_eop", w, s, 1);
         exp_nv[w] = -1;
      end
      if (v && stall[w]) begin
         chk("hold_data", w, d, hd[w]);
         chk("hold_idx", w, idx, hi[w]);
         chk("hold_sop", w, s, hs[w]);
         chk("hold_eop", w, e, he[w]);
      end
      stall[w] = v && !fft_ready;
      hd[w] = d; hi[w] = idx; hs[w] = s; he[w] = e;
      if (v && fft_ready) begin
         qs = (w == 0) ? q0.size() : q1.size();
         if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow dut%0d: got beat 0x%0h expected no beat", w, d);
         end else begin
            exp = (w == 0) ? q0.pop_front() : q1.pop_front();
            chk("data", w, d, exp);
            chk("idx", w, idx, beat[w]);
            chk("sop", w, s, beat[w] == 0);
            chk("eop", w, e, beat[w] == FL - 1);
            if (s) sops[w]++;
            beat[w]++;
            if (beat[w] == FL) begin
               beat[w] = 0;
               frames[w]++;
               exp_nv[w] = (qs - 1 >= FL) ? 1 : 0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, v0, s0, e0, i0, d0);
         mon(1, v1, s1, e1, i1, d1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sb();
      q0.delete();
      q1.delete();
      for (int w = 0; w < 2; w++) begin
         beat[w] = 0; frames[w] = 0; sops[w] = 0; exp_nv[w] = -1; stall[w] = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      din_valid = 1'b0;
      repeat (n) tick();
      clear_sb();
      rst_n = 1'b1;
   endtask

   task automatic wr(input logic signed [IN_W-1:0] x, input bit accept);
      din = x;
      din_valid = 1'b1;
      if (accept) begin
         q0.push_back(conv(x, 0));
         q1.push_back(conv(x, 5));
      end
      tick();
      din_valid = 1'b0;
   endtask

   task automatic wr_exp(input logic signed [IN_W-1:0] x, input logic [31:0] e0v, input logic [31:0] e5v);
      din = x;
      din_valid = 1'b1;
      q0.push_back(e0v);
      q1.push_back(e5v);
      tick();
      din_valid = 1'b0;
   endtask

   task automatic wait_frames(input int target, input int budget);
      int n;
      n = 0;
      while ((frames[0] < target || frames[1] < target) && n < budget) begin
         tick();
         n++;
      end
      chk("frame_timeout", 0, n < budget, 1);
      tick();
   endtask

   task automatic chk_zero();
      chk("rst_valid", 0, v0, 0);  chk("rst_valid", 1, v1, 0);
      chk("rst_sop", 0, s0, 0);    chk("rst_sop", 1, s1, 0);
      chk("rst_eop", 0, e0, 0);    chk("rst_eop", 1, e1, 0);
      chk("rst_data", 0, d0, 0);   chk("rst_data", 1, d1, 0);
      chk("rst_idx", 0, i0, 0);    chk("rst_idx", 1, i1, 0);
      chk("rst_level", 0, l0, 0);  chk("rst_level", 1, l1, 0);
      chk("rst_ovf", 0, o0, 0);    chk("rst_ovf", 1, o1, 0);
      chk("rst_drop", 0, dc0, 0);  chk("rst_drop", 1, dc1, 0);
      chk("rst_frames", 0, fc0, 0); chk("rst_frames", 1, fc1, 0);
   endtask

   function automatic logic signed [IN_W-1:0] rnd37();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[IN_W-1:0];
   endfunction

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic signed [IN_W-1:0] x;

      tbl[0] = '{37'h08_0000_0000, 32'h7FFF_FFFF, 32'h4000_0000};
      tbl[1] = '{37'h18_0000_0000, 32'h8000_0000, 32'hC000_0000};
      tbl[2] = '{37'h1F_FFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      tbl[3] = '{37'h1F_FFFF_FFC0, 32'hFFFF_FFC0, 32'hFFFF_FFFE};
      tbl[4] = '{37'h0F_FFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
      tbl[5] = '{37'h10_0000_0000, 32'h8000_0000, 32'h8000_0000};
      tbl[6] = '{37'h00_7FFF_FFFF, 32'h7FFF_FFFF, 32'h03FF_FFFF};
      tbl[7] = '{37'h00_8000_0000, 32'h7FFF_FFFF, 32'h0400_0000};
      tbl[8] = '{37'h1F_7FFF_FFFF, 32'h8000_0000, 32'hFBFF_FFFF};
      tbl[9] = '{37'h00_0000_0000, 32'h0000_0000, 32'h0000_0000};

      din = '0;
      din_valid = 1'b0;
      fft_ready = 1'b1;
      rst_n = 1'b0;
      clear_sb();

      // Reset and idle with FRAME_LEN-1 samples buffered
      do_reset(3);
      @(negedge clk);
      chk_zero();
      tick();
      for (int i = 0; i < FL - 1; i++) wr(IN_W'(i), 1'b1);
      @(negedge clk);
      chk("t1_level", 0, l0, FL - 1);
      chk("t1_valid", 0, v0, 0);
      repeat (4) tick();
      @(negedge clk);
      chk("t1_valid_late", 0, v0, 0);
      chk("t1_valid_late", 1, v1, 0);

      // Single frame: sop two cycles after the completing write
      tick();
      wr(IN_W'(FL - 1), 1'b1);
      @(negedge clk);
      chk("t2_valid_n", 0, v0, 0);
      chk("t2_level_n", 0, l0, FL);
      @(negedge clk);
      chk("t2_valid_n1", 0, v0, 1);
      chk("t2_sop_n1", 0, s0, 1);
      chk("t2_data_n1", 0, d0, 0);
      tick();
      wait_frames(1, 3000);
      chk("t2_frame_cnt", 0, fc0, 1);
      chk("t2_frame_cnt", 1, fc1, 1);
      chk("t2_valid_end", 0, v0, 0);
      chk("t2_level_end", 0, l0, 0);

      // Backpressure: ready toggles throughout the frame
      for (int i = 0; i < FL; i++) wr(rnd37(), 1'b1);
      n = 0;
      while ((frames[0] < 2 || frames[1] < 2) && n < 5000) begin
         fft_ready = (n % 2 == 0);
         tick();
         n++;
      end
      fft_ready = 1'b1;
      chk("t3_timeout", 0, n < 5000, 1);
      tick();
      chk("t3_frame_cnt", 0, fc0, 2);
      chk("t3_sops", 0, sops[0], 2);
      chk("t3_sb_left", 0, q0.size(), 0);
      chk("t3_sb_left", 1, q1.size(), 0);

      // Conversion table, then shifted random fill to complete the frame
      do_reset(2);
      for (int i = 0; i < 10; i++) wr_exp(tbl[i].din, tbl[i].exp0, tbl[i].exp5);
      for (int i = 10; i < FL; i++) begin
         x = rnd37();
         x = x >>> (i % 8);
         wr(x, 1'b1);
      end
      wait_frames(1, 3000);
      chk("t4_frame_cnt", 1, fc1, 1);
      chk("t4_sb_left", 0, q0.size(), 0);

      // Overflow: one word sits in the output register, so 2049 are accepted
      do_reset(2);
      fft_ready = 1'b0;
      for (int i = 0; i < 2101; i++) wr(IN_W'(i), i < 2049);
      @(negedge clk);
      chk("t5_level", 0, l0, 2048);
      chk("t5_drop", 0, dc0, 52);
      chk("t5_drop", 1, dc1, 52);
      chk("t5_ovf", 0, o0, 1);
      chk("t5_ovf", 1, o1, 1);
      tick();
      fft_ready = 1'b1;
      wait_frames(2, 5000);
      chk("t5_frame_cnt", 0, fc0, 2);
      chk("t5_sops", 0, sops[0], 2);
      chk("t5_level_end", 0, l0, 1);
      chk("t5_sb_left", 0, q0.size(), 1);

      // Reset in the middle of a frame
      do_reset(2);
      @(negedge clk);
      chk("t6_frame0", 0, fc0, 0);
      tick();
      for (int i = 0; i < FL; i++) wr(rnd37(), 1'b1);
      n = 0;
      while (!(v0 && i0 >= 10'd500) && n < 3000) begin
         tick();
         n++;
      end
      chk("t6_reach500", 0, n < 3000, 1);
      do_reset(1);
      @(negedge clk);
      chk_zero();
      tick();
      for (int i = 0; i < FL; i++) wr(rnd37(), 1'b1);
      wait_frames(1, 3000);
      chk("t6_frame_cnt", 0, fc0, 1);
      chk("t6_sops", 0, sops[0], 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
